// File: rtl/call_request_latch_if.sv
// ---------------------------------------------------------------------------
// call_request_latch_if
//   Bundles the button, car-status and latched-call signals of the
//   call_request_latch stage.
//   Signals:
//     btn_raw[6:0]  raw buttons {f3,f2,f1,d3,d2,u2,u1}, bit0=u1 ... bit6=f3
//     fs[1:0]       car floor: 01=F1, 10=F2, 11=F3, 00=between floors
//     door          1 = door open
//     dir[1:0]      car direction: 01=up, 10=down, 00/11=idle
//     UP1..FLOOR3   latched hall/car calls
//     pending[2:0]  number of latched calls
//     any_call      pending != 0
//   Modports:
//     master  drives buttons and car status, observes calls (environment)
//     slave   the latch itself
// ---------------------------------------------------------------------------
interface call_request_latch_if;
  logic [6:0] btn_raw;
  logic [1:0] fs;
  logic       door;
  logic [1:0] dir;
  logic       UP1;
  logic       UP2;
  logic       DOWN2;
  logic       DOWN3;
  logic       FLOOR1;
  logic       FLOOR2;
  logic       FLOOR3;
  logic [2:0] pending;
  logic       any_call;

  modport master (
    output btn_raw, fs, door, dir,
    input  UP1, UP2, DOWN2, DOWN3, FLOOR1, FLOOR2, FLOOR3, pending, any_call
  );

  modport slave (
    input  btn_raw, fs, door, dir,
    output UP1, UP2, DOWN2, DOWN3, FLOOR1, FLOOR2, FLOOR3, pending, any_call
  );
endinterface

// File: rtl/call_request_latch.sv
// ---------------------------------------------------------------------------
// call_request_latch
//   Upstream stage of the elevator controller. Debounces the seven raw
//   hall/car buttons, latches each accepted press as a pending call and
//   clears a call when the car serves it (door open at that floor in a
//   compatible direction). Also reports the number of pending calls.
//
//   Ports:
//     clk   system clock, rising edge
//     rst   synchronous, active-low reset
//     bus   call_request_latch_if.slave (buttons, car status, calls, count)
//
//   Parameters:
//     DEB_CYCLES  consecutive identical raw samples needed to change a
//                 debounced level (>= 1)
//
//   Build option:
//     CAR_CALL_CANCEL_EN  when defined, a fresh press of an already latched
//                         car call (FLOOR1-3) cancels it. Hall calls are
//                         always set-only.
//
//   Call vector bit order matches btn_raw:
//     0=UP1 1=UP2 2=DOWN2 3=DOWN3 4=FLOOR1 5=FLOOR2 6=FLOOR3
// ---------------------------------------------------------------------------
module call_request_latch #(
  parameter int DEB_CYCLES = 4
) (
  input logic                 clk,
  input logic                 rst,
  call_request_latch_if.slave bus
);

  localparam int             NB       = 7;
  localparam int             CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [NB-1:0]  CAR_MASK = 7'b111_0000;

  logic [CW-1:0] cnt_q [NB];
  logic [CW-1:0] cnt_d [NB];
  logic [NB-1:0] deb_q, deb_d;
  logic [NB-1:0] deb_prev_q, deb_prev_d;
  logic [NB-1:0] call_q, call_d;
  logic [2:0]    pending_q, pending_d;
  logic          any_call_q, any_call_d;

  logic [NB-1:0] rise;
  logic [NB-1:0] serve;

  // Debounce: count edges where raw disagrees with the debounced level;
  // any agreeing edge restarts the count.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    deb_d = deb_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (bus.btn_raw[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // A press is accepted one edge after the debounced level goes high.
  assign deb_prev_d = deb_q;
  assign rise       = deb_q & ~deb_prev_q;

  // Serve mask: only with the door open at a real floor (fs=00 with the
  // door open is a sensor fault and clears nothing).
  always_comb begin
    serve = '0;
    if (bus.door && bus.fs != 2'b00) begin
      unique case (bus.fs)
        2'b01: serve = 7'b001_0001;          // FLOOR1, UP1
        2'b11: serve = 7'b100_1000;          // FLOOR3, DOWN3
        default: begin                       // F2
          serve[5] = 1'b1;
          unique case (bus.dir)
            2'b01:   serve[1] = 1'b1;
            2'b10:   serve[2] = 1'b1;
            default: serve[2:1] = 2'b11;     // idle serves both hall calls
          endcase
        end
      endcase
    end
  end

  // Next call vector; serve is applied last so it wins over a same-cycle set.
  always_comb begin
`ifdef CAR_CALL_CANCEL_EN
    call_d = ((call_q | (rise & ~CAR_MASK)) ^ (rise & CAR_MASK)) & ~serve;
`else
    call_d = (call_q | rise) & ~serve;
`endif
    pending_d = '0;
    for (int i = 0; i < NB; i++) begin
      pending_d = pending_d + 3'(call_d[i]);
    end
    any_call_d = |call_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the debounce counter array is small and must restart from
      // zero after reset, so it is cleared along with the scalar flops.
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      call_q     <= '0;
      pending_q  <= '0;
      any_call_q <= 1'b0;
    end else begin
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      call_q     <= call_d;
      pending_q  <= pending_d;
      any_call_q <= any_call_d;
    end
  end

  assign bus.UP1      = call_q[0];
  assign bus.UP2      = call_q[1];
  assign bus.DOWN2    = call_q[2];
  assign bus.DOWN3    = call_q[3];
  assign bus.FLOOR1   = call_q[4];
  assign bus.FLOOR2   = call_q[5];
  assign bus.FLOOR3   = call_q[6];
  assign bus.pending  = pending_q;
  assign bus.any_call = any_call_q;

endmodule

// File: tb/tb_call_request_latch.sv
// ---------------------------------------------------------------------------
// tb_call_request_latch
//   Directed bench for call_request_latch with DEB_CYCLES = 4.
//   Inputs change and outputs are sampled 1 time unit after each rising edge.
//   Call vector order: {FLOOR3,FLOOR2,FLOOR1,DOWN3,DOWN2,UP2,UP1}.
// ---------------------------------------------------------------------------
module tb_call_request_latch;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  call_request_latch_if bus ();

  call_request_latch #(.DEB_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic [6:0] calls;
  assign calls = {bus.FLOOR3, bus.FLOOR2, bus.FLOOR1, bus.DOWN3,
                  bus.DOWN2, bus.UP2, bus.UP1};

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [6:0] exp_calls,
                           input logic [2:0] exp_pend);
    check({tag, ".calls"},    {1'b0, calls},           {1'b0, exp_calls});
    check({tag, ".pending"},  {5'd0, bus.pending},     {5'd0, exp_pend});
    check({tag, ".any_call"}, {7'd0, bus.any_call},    {7'd0, exp_pend != 3'd0});
  endtask

  initial begin
    rst         = 1'b0;
    bus.btn_raw = 7'h7f;
    bus.fs      = 2'b00;
    bus.door    = 1'b0;
    bus.dir     = 2'b00;

    // 1: reset with every button held, then re-debounce after release
    tick(2);
    check_all("rst_held", 7'h00, 3'd0);
    rst = 1'b1;
    tick(4);
    check_all("rst_rel_4", 7'h00, 3'd0);
    tick(1);
    check_all("rst_rel_5", 7'h7f, 3'd7);

    // clean restart
    rst         = 1'b0;
    bus.btn_raw = 7'h00;
    tick(1);
    rst = 1'b1;
    check_all("restart", 7'h00, 3'd0);

    // 2: short pulse ignored, full press latches, hold does not re-trigger
    bus.btn_raw = 7'h02;
    tick(3);
    bus.btn_raw = 7'h00;
    tick(6);
    check_all("short_u2", 7'h00, 3'd0);
    bus.btn_raw = 7'h02;
    tick(4);
    check_all("u2_edge4", 7'h00, 3'd0);
    tick(1);
    check_all("u2_edge5", 7'h02, 3'd1);
    tick(3);
    check_all("u2_hold", 7'h02, 3'd1);
    bus.btn_raw = 7'h00;
    tick(4);

    // 3: F2 serve by direction
    bus.btn_raw = 7'h04;
    tick(5);
    check_all("d2_set", 7'h06, 3'd2);
    bus.btn_raw = 7'h00;
    tick(5);
    bus.fs   = 2'b10;
    bus.door = 1'b1;
    bus.dir  = 2'b01;
    tick(1);
    check_all("f2_up", 7'h04, 3'd1);
    bus.dir = 2'b00;
    tick(1);
    check_all("f2_idle", 7'h00, 3'd0);
    bus.door = 1'b0;
    bus.fs   = 2'b00;

    // 4: serve wins over a same-cycle set
    bus.btn_raw = 7'h01;
    tick(5);
    check_all("u1_set", 7'h01, 3'd1);
    bus.btn_raw = 7'h40;
    bus.fs      = 2'b11;
    bus.door    = 1'b1;
    tick(5);
    check_all("f3_serve_wins", 7'h01, 3'd1);
    bus.btn_raw = 7'h00;
    bus.door    = 1'b0;
    bus.fs      = 2'b00;
    tick(5);

    // 5: door open between floors clears nothing; then F1 serve
    bus.btn_raw = 7'h7f;
    tick(5);
    check_all("all_set", 7'h7f, 3'd7);
    bus.btn_raw = 7'h00;
    tick(5);
    bus.door = 1'b1;
    bus.fs   = 2'b00;
    tick(3);
    check_all("fs00_fault", 7'h7f, 3'd7);
    bus.fs = 2'b01;
    tick(1);
    check_all("f1_serve", 7'h6e, 3'd5);
    bus.door = 1'b0;
    bus.fs   = 2'b00;

    // 6: re-press of a latched FLOOR2, then re-press of a latched hall call
    bus.btn_raw = 7'h20;
    tick(5);
`ifdef CAR_CALL_CANCEL_EN
    check_all("f2_repress", 7'h4e, 3'd4);
`else
    check_all("f2_repress", 7'h6e, 3'd5);
`endif
    bus.btn_raw = 7'h00;
    tick(5);
    bus.btn_raw = 7'h02;
    tick(5);
`ifdef CAR_CALL_CANCEL_EN
    check_all("u2_repress", 7'h4e, 3'd4);
`else
    check_all("u2_repress", 7'h6e, 3'd5);
`endif
    bus.btn_raw = 7'h00;
    tick(5);

    // F3 serve, then F2 heading down
    bus.door = 1'b1;
    bus.fs   = 2'b11;
    tick(1);
`ifdef CAR_CALL_CANCEL_EN
    check_all("f3_serve", 7'h06, 3'd2);
`else
    check_all("f3_serve", 7'h26, 3'd3);
`endif
    bus.fs  = 2'b10;
    bus.dir = 2'b10;
    tick(1);
    check_all("f2_down", 7'h02, 3'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
